coproc_result_readout: RTL and testbench

//  Output stage of tt_um_nickjhay_coprocessor. Takes result words from the compute core

---
 rtl/coproc_result_readout.sv | 164 ++++++++++++++++
 tb/tb_coproc_result_readout.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coproc_result_readout.sv
// Result readout stage: buffers result words in a small FIFO and presents them LSB-first,
// one byte per readout rising edge. Optional greeting mode is compiled in with `define SAYHI_EN.
module coproc_result_readout #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic              readout,
    input  logic              sayhi,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    output logic              underrun
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   sreg_q, sreg_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                underrun_q, underrun_d;
    logic                hi_q, hi_d;
    logic [7:0]          out_byte_q, out_byte_d;
    logic                out_valid_q, out_valid_d;
    logic                readout_q;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;

    logic push, pop, rise, empty, full, greet;

    `ifdef SAYHI_EN
    assign greet = sayhi;
    `else
    assign greet = 1'b0;
    wire unused_sayhi = sayhi;
    `endif

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign res_ready = !full;
    assign push      = res_valid && res_ready;
    assign rise      = readout && !readout_q;

    // ---------------- FIFO ----------------
    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    // NOTE: the storage array has no reset; stale contents are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= res_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            readout_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            readout_q <= readout;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            idx_q       <= '0;
            underrun_q  <= 1'b0;
            hi_q        <= 1'b0;
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            idx_q       <= idx_d;
            underrun_q  <= underrun_d;
            hi_q        <= hi_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        idx_d      = idx_q;
        underrun_d = underrun_q;
        hi_d       = greet ? hi_q : 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sreg_d  = mem[rd_ptr_q];
                    idx_d   = '0;
                    hi_d    = 1'b0;
                    state_d = PRESENT;
                end else if (rise) begin
                    if (greet) hi_d = !hi_q;
                    else       underrun_d = 1'b1;
                end
            end
            PRESENT: begin
                if (rise) begin
                    if (idx_q != LAST_IDX) begin
                        sreg_d = sreg_q >> 8;
                        idx_d  = idx_q + 1'b1;
                    end else if (!empty) begin
                        // Back-to-back words: reload on the same edge to avoid an IDLE gap.
                        pop    = 1'b1;
                        sreg_d = mem[rd_ptr_q];
                        idx_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // ---------------- FSM: outputs (computed from next state, then registered) ----------------
    always_comb begin
        out_valid_d = (state_d == PRESENT);
        if (state_d == PRESENT)
            out_byte_d = sreg_d[7:0];
        else if (greet)
            out_byte_d = hi_d ? 8'h49 : 8'h48;
        else
            out_byte_d = 8'h00;
    end

    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_coproc_result_readout.sv
// Self-checking bench for coproc_result_readout: directed scenarios plus a randomized run,
// all compared against a queue-based byte-stream model.
module tb_coproc_result_readout;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int BYTES  = DATA_W / 8;
    `ifdef SAYHI_EN
    localparam bit GREET_EN = 1'b1;
    `else
    localparam bit GREET_EN = 1'b0;
    `endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic              res_ready;
    logic              readout;
    logic              sayhi;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              underrun;

    coproc_result_readout #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .readout   (readout),
        .sayhi     (sayhi),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: words waiting, bytes of the word on display, and sticky flags.
    logic [DATA_W-1:0] m_fifo[$];
    logic [7:0]        m_bytes[$];
    bit                m_pres;
    bit                m_under;
    bit                m_prev;
    bit                m_hi;
    bit                m_sayhi;
    logic [DATA_W-1:0] pending[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_bytes.delete();
        m_pres  = 1'b0;
        m_under = 1'b0;
        m_prev  = 1'b0;
        m_hi    = 1'b0;
        m_sayhi = 1'b0;
    endtask

    task automatic model_load();
        logic [DATA_W-1:0] w;
        w = m_fifo.pop_front();
        m_bytes.delete();
        for (int i = 0; i < BYTES; i++) m_bytes.push_back(w[8*i +: 8]);
        m_pres = 1'b1;
        m_hi   = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [7:0] exp_byte;
        if (m_pres)                   exp_byte = m_bytes[0];
        else if (GREET_EN && m_sayhi) exp_byte = m_hi ? 8'h49 : 8'h48;
        else                          exp_byte = 8'h00;
        check({tag, ".out_byte"},  out_byte,  exp_byte);
        check({tag, ".out_valid"}, out_valid, m_pres);
        check({tag, ".res_ready"}, res_ready, m_fifo.size() < DEPTH);
        check({tag, ".underrun"},  underrun,  m_under);
    endtask

    // One clock: drive inputs (called at negedge), advance model across the edge, check at negedge.
    task automatic step(input bit rd, input bit sh, input string tag);
        bit push, rise;
        res_valid = (pending.size() > 0);
        res_data  = (pending.size() > 0) ? pending[0] : DATA_W'($urandom);
        readout   = rd;
        sayhi     = sh;
        push = res_valid && (m_fifo.size() < DEPTH);
        rise = rd && !m_prev;
        @(posedge clk);
        if (!(GREET_EN && sh)) m_hi = 1'b0;
        if (!m_pres) begin
            if (m_fifo.size() > 0) model_load();
            else if (rise) begin
                if (GREET_EN && sh) m_hi = !m_hi;
                else                m_under = 1'b1;
            end
        end else if (rise) begin
            void'(m_bytes.pop_front());
            if (m_bytes.size() == 0) begin
                if (m_fifo.size() > 0) model_load();
                else                   m_pres = 1'b0;
            end
        end
        if (push) begin
            m_fifo.push_back(res_data);
            void'(pending.pop_front());
        end
        m_prev  = rd;
        m_sayhi = sh;
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic pulse(input bit sh, input string tag);
        step(1'b1, sh, tag);
        step(1'b0, sh, tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        res_valid = 1'b0;
        readout   = 1'b0;
        sayhi     = 1'b0;
        pending.delete();
        #3;
        check({tag, ".out_byte"},  out_byte,  8'h00);
        check({tag, ".out_valid"}, out_valid, 1'b0);
        check({tag, ".res_ready"}, res_ready, 1'b1);
        check({tag, ".underrun"},  underrun,  1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] words[4];
        logic [DATA_W-1:0] w;
        logic [7:0]        exp_b;

        rst_n     = 1'b0;
        res_data  = '0;
        res_valid = 1'b0;
        readout   = 1'b0;
        sayhi     = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state
        do_reset("reset");

        // Single word, LSB first, then drain to IDLE
        pending.push_back(32'hDEADBEEF);
        step(1'b0, 1'b0, "push");
        check("push.latency_valid", out_valid, 1'b0);
        step(1'b0, 1'b0, "load");
        check("load.byte0", out_byte, 8'hEF);
        check("load.valid", out_valid, 1'b1);
        pulse(1'b0, "p1");
        check("p1.byte", out_byte, 8'hBE);
        pulse(1'b0, "p2");
        check("p2.byte", out_byte, 8'hAD);
        pulse(1'b0, "p3");
        check("p3.byte", out_byte, 8'hDE);
        pulse(1'b0, "p4");
        check("p4.valid", out_valid, 1'b0);
        check("p4.byte", out_byte, 8'h00);

        // Four words with res_valid held: backpressure and ordering
        words = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
        for (int i = 0; i < 4; i++) pending.push_back(words[i]);
        step(1'b0, 1'b0, "burst1");
        step(1'b0, 1'b0, "burst2");
        step(1'b0, 1'b0, "burst3");
        check("burst.ready_after_3rd", res_ready, 1'b0);
        for (int k = 0; k < 4 * BYTES; k++) begin
            w = words[k / BYTES];
            exp_b = w[8 * (k % BYTES) +: 8];
            check($sformatf("burst.byte%0d", k), out_byte, exp_b);
            pulse(1'b0, "burst_pulse");
        end
        check("burst.drained", out_valid, 1'b0);

        // Level held high: exactly one advance
        pending.push_back(32'hCAFEF00D);
        step(1'b0, 1'b0, "hold_push");
        step(1'b0, 1'b0, "hold_load");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "hold_high");
        step(1'b0, 1'b0, "hold_low");
        check("hold.one_advance", out_byte, 8'hF0);
        for (int i = 0; i < BYTES - 1; i++) pulse(1'b0, "hold_drain");

        // Underrun with empty FIFO, sticky until reset
        pulse(1'b0, "under");
        check("under.flag", underrun, 1'b1);
        check("under.byte", out_byte, 8'h00);
        check("under.valid", out_valid, 1'b0);
        pending.push_back(32'h0BADC0DE);
        step(1'b0, 1'b0, "under_push");
        step(1'b0, 1'b0, "under_load");
        for (int i = 0; i < BYTES; i++) pulse(1'b0, "under_drain");
        check("under.sticky", underrun, 1'b1);

        // Reset partway through a word
        pending.push_back(32'hA1B2C3D4);
        pending.push_back(32'h01020304);
        step(1'b0, 1'b0, "mid_push");
        step(1'b0, 1'b0, "mid_load");
        pulse(1'b0, "mid_p1");
        pulse(1'b0, "mid_p2");
        check("mid.byte2", out_byte, 8'hB2);
        do_reset("mid_reset");
        pending.push_back(32'h5A6B7C8D);
        step(1'b0, 1'b0, "post_push");
        step(1'b0, 1'b0, "post_load");
        check("post.byte0", out_byte, 8'h8D);
        for (int i = 0; i < BYTES; i++) pulse(1'b0, "post_drain");

        `ifdef SAYHI_EN
        step(1'b0, 1'b1, "hi_enter");
        check("hi.H", out_byte, 8'h48);
        pulse(1'b1, "hi_p1");
        check("hi.I", out_byte, 8'h49);
        pulse(1'b1, "hi_p2");
        check("hi.H2", out_byte, 8'h48);
        check("hi.no_underrun", underrun, 1'b0);
        pending.push_back(32'h01020304);
        step(1'b0, 1'b1, "hi_push");
        step(1'b0, 1'b1, "hi_load");
        check("hi.data_byte", out_byte, 8'h04);
        check("hi.data_valid", out_valid, 1'b1);
        for (int i = 0; i < BYTES; i++) pulse(1'b1, "hi_drain");
        `endif

        // Randomized traffic against the model, with one reset in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset("rand_reset");
            if (pending.size() < 2 && ($urandom % 3) == 0) pending.push_back($urandom);
            step(($urandom % 3) == 0, $urandom % 2, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
